// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: measures line/frame timing, locks to the expected raster
// and reports per-pixel coordinates and colour two cycles after the input sample.
module vga_rx_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iVGA_H_SYNC,
  input  logic        iVGA_V_SYNC,
  input  logic        iVGA_BLANK,
  input  logic [9:0]  iVGA_R,
  input  logic [9:0]  iVGA_G,
  input  logic [9:0]  iVGA_B,
  output logic [9:0]  oR,
  output logic [9:0]  oG,
  output logic [9:0]  oB,
  output logic [9:0]  oX,
  output logic [9:0]  oY,
  output logic        oPixel_valid,
  output logic        oFrame_start,
  output logic        oLocked,
  output logic [2:0]  oErr,
  output logic [10:0] oH_meas,
  output logic [9:0]  oV_meas
);

  localparam logic [10:0] HT    = 11'(H_TOTAL);
  localparam logic [9:0]  VT    = 10'(V_TOTAL);
  localparam logic [9:0]  HA    = 10'(H_ACTIVE);
  localparam logic [9:0]  VA    = 10'(V_ACTIVE);
  localparam logic [7:0]  LF    = 8'(LOCK_FRAMES);
  localparam logic [10:0] H_SAT = '1;
  localparam logic [9:0]  V_SAT = '1;

  typedef enum logic [1:0] {SEARCH, SYNC, LOCKED} state_t;

  logic        r_hs, r_vs, r_blank, r_hs_d, r_vs_d, r_blank_d;
  logic [9:0]  r_r, r_g, r_b;
  logic [10:0] r_hcnt;
  logic [9:0]  r_vcnt;
  logic        r_lines_ok, r_first;
  logic [7:0]  r_good;
  state_t      r_state;

  logic        w_hs_fall, w_vs_fall, w_blank_rise;
  logic [10:0] w_hlen;
  logic        w_line_bad, w_hs_stuck, w_frame_bad, w_frame_ok;
  logic [9:0]  w_x_nxt, w_y_nxt;
  logic        w_first_nxt, w_ovf, w_valid;

  // Idle values of 1 keep the edge detectors quiet coming out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank   <= 1'b1;
      r_hs_d    <= 1'b1;
      r_vs_d    <= 1'b1;
      r_blank_d <= 1'b1;
      r_r       <= '0;
      r_g       <= '0;
      r_b       <= '0;
    end else begin
      r_hs      <= iVGA_H_SYNC;
      r_vs      <= iVGA_V_SYNC;
      r_blank   <= iVGA_BLANK;
      r_hs_d    <= r_hs;
      r_vs_d    <= r_vs;
      r_blank_d <= r_blank;
      r_r       <= iVGA_R;
      r_g       <= iVGA_G;
      r_b       <= iVGA_B;
    end
  end

  assign w_hs_fall    = r_hs_d & ~r_hs;
  assign w_vs_fall    = r_vs_d & ~r_vs;
  assign w_blank_rise = r_blank & ~r_blank_d;
  assign w_hlen       = (r_hcnt == H_SAT) ? H_SAT : r_hcnt + 11'd1;
  assign w_line_bad   = w_hs_fall && (w_hlen != HT);
  assign w_hs_stuck   = !w_hs_fall && (r_hcnt == H_SAT);
  assign w_frame_bad  = w_vs_fall && (r_vcnt != VT);
  // A sync edge coinciding with VS closes the last line of the old frame.
  assign w_frame_ok   = r_lines_ok && !w_line_bad && (r_vcnt == VT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_lines_ok <= 1'b0;
      oH_meas    <= '0;
      oV_meas    <= '0;
    end else begin
      if (w_hs_fall) begin
        r_hcnt  <= '0;
        oH_meas <= w_hlen;
      end else if (r_hcnt != H_SAT) begin
        r_hcnt <= r_hcnt + 11'd1;
      end
      if (w_vs_fall) begin
        oV_meas    <= r_vcnt;
        r_vcnt     <= w_hs_fall ? 10'd1 : 10'd0;
        r_lines_ok <= 1'b1;
      end else begin
        if (w_hs_fall && r_vcnt != V_SAT) r_vcnt <= r_vcnt + 10'd1;
        if (w_line_bad || w_hs_stuck) r_lines_ok <= 1'b0;
      end
    end
  end

  always_comb begin
    w_x_nxt     = oX;
    w_y_nxt     = oY;
    w_first_nxt = r_first;
    if (w_vs_fall) begin
      w_y_nxt     = '0;
      w_first_nxt = 1'b1;
    end
    if (w_blank_rise) begin
      w_x_nxt = '0;
      if (w_first_nxt) w_first_nxt = 1'b0;
      else if (w_y_nxt != VA) w_y_nxt = w_y_nxt + 10'd1;
    end else if (r_blank && oX != HA) begin
      w_x_nxt = oX + 10'd1;
    end
  end

  assign w_ovf   = r_blank && (w_x_nxt == HA || w_y_nxt == VA);
  assign w_valid = r_blank && !w_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      oX           <= '0;
      oY           <= '0;
      r_first      <= 1'b0;
      oPixel_valid <= 1'b0;
      oR           <= '0;
      oG           <= '0;
      oB           <= '0;
      oFrame_start <= 1'b0;
    end else begin
      oX           <= w_x_nxt;
      oY           <= w_y_nxt;
      r_first      <= w_first_nxt;
      oPixel_valid <= w_valid;
      oR           <= w_valid ? r_r : 10'd0;
      oG           <= w_valid ? r_g : 10'd0;
      oB           <= w_valid ? r_b : 10'd0;
      oFrame_start <= w_vs_fall;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEARCH;
      r_good  <= '0;
      oLocked <= 1'b0;
      oErr    <= '0;
    end else begin
      if (w_ovf) oErr[2] <= 1'b1;
      case (r_state)
        SEARCH: if (w_vs_fall) begin
          r_state <= SYNC;
          r_good  <= '0;
        end
        SYNC: if (w_vs_fall) begin
          if (!w_frame_ok) begin
            r_good <= '0;
          end else if (r_good + 8'd1 >= LF) begin
            r_state <= LOCKED;
            r_good  <= '0;
            oLocked <= 1'b1;
          end else begin
            r_good <= r_good + 8'd1;
          end
        end
        LOCKED: begin
          if (w_line_bad || w_hs_stuck) oErr[0] <= 1'b1;
          if (w_frame_bad) oErr[1] <= 1'b1;
          if (w_line_bad || w_hs_stuck || w_frame_bad) begin
            r_state <= SEARCH;
            oLocked <= 1'b0;
          end
        end
        default: begin
          r_state <= SEARCH;
          oLocked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Randomized raster stimulus for vga_rx_monitor, checked against a frame-geometry
// model: each driven cycle predicts the output seen two cycles later.
module tb_vga_rx_monitor;

  localparam int HT = 40, VT = 20, HA = 24, VA = 12, LF = 2;

  logic        clk, reset;
  logic        iVGA_H_SYNC, iVGA_V_SYNC, iVGA_BLANK;
  logic [9:0]  iVGA_R, iVGA_G, iVGA_B;
  logic [9:0]  oR, oG, oB, oX, oY;
  logic        oPixel_valid, oFrame_start, oLocked;
  logic [2:0]  oErr;
  logic [10:0] oH_meas;
  logic [9:0]  oV_meas;

  vga_rx_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
                   .LOCK_FRAMES(LF)) dut (
    .clk(clk), .reset(reset),
    .iVGA_H_SYNC(iVGA_H_SYNC), .iVGA_V_SYNC(iVGA_V_SYNC), .iVGA_BLANK(iVGA_BLANK),
    .iVGA_R(iVGA_R), .iVGA_G(iVGA_G), .iVGA_B(iVGA_B),
    .oR(oR), .oG(oG), .oB(oB), .oX(oX), .oY(oY),
    .oPixel_valid(oPixel_valid), .oFrame_start(oFrame_start), .oLocked(oLocked),
    .oErr(oErr), .oH_meas(oH_meas), .oV_meas(oV_meas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v, cxy;
    logic [9:0] x, y, r, g, b;
    logic       fs;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0, n_err = 0;
  int          nvalid = 0, fvalid = 0;
  logic [9:0]  lx, ly;
  logic        prev_vs = 1'b1;
  logic        l1, l2, cap_lock;
  logic [10:0] cap_meas;
  logic [2:0]  cap_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One raster cycle; ex/ey are the pixel's position within the active area.
  task automatic drive(input logic hs, input logic vs, input logic bl,
                       input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                       input int ex, input int ey);
    exp_t e, f;
    @(negedge clk);
    if (q.size() == 2) begin
      f = q.pop_front();
      chk("fstart", 64'(oFrame_start), 64'(f.fs));
      chk("pixel", 64'({oPixel_valid, (f.cxy ? oX : 10'd0), (f.cxy ? oY : 10'd0), oR, oG, oB}),
                   64'({f.v, f.x, f.y, f.r, f.g, f.b}));
      if (oPixel_valid) begin nvalid++; lx = oX; ly = oY; end
    end
    iVGA_H_SYNC = hs; iVGA_V_SYNC = vs; iVGA_BLANK = bl;
    iVGA_R = r; iVGA_G = g; iVGA_B = b;
    e.fs   = prev_vs & ~vs;
    prev_vs = vs;
    e.v    = bl && ex < HA && ey < VA;
    e.cxy  = bl;
    e.x    = bl ? 10'(ex) : 10'd0;
    e.y    = bl ? 10'(ey) : 10'd0;
    e.r    = e.v ? r : 10'd0;
    e.g    = e.v ? g : 10'd0;
    e.b    = e.v ? b : 10'd0;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 1'b1, 1'b0, 10'($urandom), 10'($urandom), 10'($urandom), 0, 0);
  endtask

  // First four cycles of line 0: HS and VS fall together.
  task automatic peek();
    for (int h = 0; h < 4; h++) begin
      drive(1'b0, 1'b0, 1'b0, 10'($urandom), 10'($urandom), 10'($urandom), 0, 0);
      if (h == 1) l1 = oLocked;
      if (h == 2) l2 = oLocked;
    end
    fvalid = nvalid;
    nvalid = 0;
  endtask

  task automatic run_frame(input int nlines, input int badline, input int badlen,
                           input int ovf_row, input int first_h);
    int hs0, vs0, len, wlen, ex, ey;
    logic bl;
    hs0 = int'($urandom_range(5, HT - HA - 1));
    vs0 = int'($urandom_range(2, VT - VA - 1));
    for (int v = 0; v < nlines; v++) begin
      len = (v == badline) ? badlen : HT;
      for (int h = (v == 0) ? first_h : 0; h < len; h++) begin
        ex   = h - hs0;
        ey   = v - vs0;
        wlen = (ey == ovf_row) ? HA + 1 : HA;
        bl   = ey >= 0 && ey < VA && ex >= 0 && ex < wlen;
        if (bl) drive(h >= 4, v >= 2, 1'b1, 10'(ex), 10'(ey), 10'($urandom), ex, ey);
        else    drive(h >= 4, v >= 2, 1'b0, 10'($urandom), 10'($urandom), 10'($urandom), 0, 0);
        if (v == badline + 1 && h == 3) begin
          cap_meas = oH_meas; cap_lock = oLocked; cap_err = oErr;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    iVGA_H_SYNC = 1'b1; iVGA_V_SYNC = 1'b1; iVGA_BLANK = 1'b0;
    iVGA_R = 10'($urandom); iVGA_G = 10'($urandom); iVGA_B = 10'($urandom);
    @(negedge clk);
    chk("rst_pix", 64'({oR, oG, oB, oX, oY}), 64'd0);
    chk("rst_ctl", 64'({oPixel_valid, oFrame_start, oLocked, oErr, oH_meas, oV_meas}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    prev_vs = 1'b1;
  endtask

  // Lock acquisition from SEARCH: VS entry then LF good frames.
  task automatic acquire(input string tag);
    peek();
    chk({tag, "_entry"}, 64'(oLocked), 64'd0);
    run_frame(VT, -1, 0, -1, 4);
    peek();
    chk({tag, "_good1"}, 64'(oLocked), 64'd0);
    run_frame(VT, -1, 0, -1, 4);
    peek();
    chk({tag, "_lock"}, 64'(oLocked), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    iVGA_H_SYNC = 1'b1; iVGA_V_SYNC = 1'b1; iVGA_BLANK = 1'b0;
    iVGA_R = '0; iVGA_G = '0; iVGA_B = '0;
    do_reset();
    idle(5);

    // acquisition with exact latency of the lock rise
    peek();
    chk("acq_entry", 64'(oLocked), 64'd0);
    run_frame(VT, -1, 0, -1, 4);
    peek();
    chk("acq_good1", 64'(oLocked), 64'd0);
    chk("vmeas", 64'(oV_meas), 64'(VT));
    chk("hmeas", 64'(oH_meas), 64'(HT));
    run_frame(VT, -1, 0, -1, 4);
    peek();
    chk("lock_early", 64'(l1), 64'd0);
    chk("lock_rise", 64'(l2), 64'd1);
    chk("err_clean", 64'(oErr), 64'd0);

    // a full locked frame: pixel count and last pixel
    run_frame(VT, -1, 0, -1, 4);
    peek();
    chk("frame_pixels", 64'(fvalid), 64'(HA * VA));
    chk("last_xy", 64'({lx, ly}), 64'({10'(HA - 1), 10'(VA - 1)}));
    chk("still_locked", 64'(oLocked), 64'd1);

    // one short line while locked
    run_frame(VT, int'($urandom_range(3, VT - 2)), HT - 1, -1, 4);
    chk("badline_meas", 64'(cap_meas), 64'(HT - 1));
    chk("badline_unlock", 64'(cap_lock), 64'd0);
    chk("badline_err", 64'(cap_err), 64'd1);
    acquire("relock_line");
    chk("err_sticky", 64'(oErr), 64'd1);

    // one short frame while locked; must drop back to SEARCH, not SYNC
    run_frame(VT - 1, -1, 0, -1, 4);
    peek();
    chk("short_err", 64'(oErr), 64'd3);
    chk("short_vmeas", 64'(oV_meas), 64'(VT - 1));
    chk("short_unlock", 64'(oLocked), 64'd0);
    run_frame(VT, -1, 0, -1, 4);
    acquire("relock_frame");

    // active-area overflow on one row
    run_frame(VT, -1, 0, int'($urandom_range(0, VA - 1)), 4);
    peek();
    chk("ovf_err", 64'(oErr), 64'd7);
    chk("ovf_locked", 64'(oLocked), 64'd1);

    // reset mid-frame, then fresh acquisition
    run_frame(VT / 2, -1, 0, -1, 4);
    do_reset();
    idle(5);
    chk("rst_err", 64'(oErr), 64'd0);
    acquire("relock_rst");

    // HS disappears while locked
    run_frame(VT / 2, -1, 0, -1, 4);
    idle(2100);
    chk("nohs_err", 64'(oErr), 64'd1);
    chk("nohs_unlock", 64'(oLocked), 64'd0);
    peek();
    chk("nohs_meas", 64'(oH_meas), 64'd2047);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
